// File: rtl/vram_cpu_adapter.sv
`default_nettype none
// ============================================================================
// vram_cpu_adapter : CPU 8/16/32-bit accesses onto the 32-bit VRAM word array
// Revision         : 1.0
// ============================================================================
module vram_cpu_adapter #(
    parameter int          MEM_AW        = 15,
    parameter logic [16:0] OBJ_BYTE_BASE = 17'h10000
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [16:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              busy,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        eff_lo_q, eff_lo_d;
    logic [15:0]       wdata_lo_q, wdata_lo_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              busy_q, busy_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_din_q, mem_din_d;

    logic [16:0]       w_eff_in;
    logic [15:0]       w_new_half;
    logic [31:0]       w_merged;
    logic [15:0]       w_rd_half;
    logic [7:0]        w_rd_byte;
    logic [31:0]       w_rd_data;

    // Upper 32KB of the 128KB window mirrors the OBJ region below it.
    always_comb begin
        w_eff_in = cpu_addr;
        if (cpu_addr[16:15] == 2'b11) begin
            w_eff_in[15] = 1'b0;
        end
    end

    // Byte stores land on both bytes of the addressed halfword.
    always_comb begin
        w_new_half = (size_q == 2'd0) ? {wdata_lo_q[7:0], wdata_lo_q[7:0]} : wdata_lo_q;
        w_merged   = eff_lo_q[1] ? {w_new_half, mem_dout[15:0]}
                                 : {mem_dout[31:16], w_new_half};
    end

    always_comb begin
        w_rd_half = eff_lo_q[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (eff_lo_q)
            2'd0:    w_rd_byte = mem_dout[7:0];
            2'd1:    w_rd_byte = mem_dout[15:8];
            2'd2:    w_rd_byte = mem_dout[23:16];
            default: w_rd_byte = mem_dout[31:24];
        endcase
        if (size_q[1]) begin
            w_rd_data = mem_dout;
        end else if (size_q[0]) begin
            w_rd_data = {w_rd_half, w_rd_half};
        end else begin
            w_rd_data = {4{w_rd_byte}};
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        eff_lo_d    = eff_lo_q;
        wdata_lo_d  = wdata_lo_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_din_d   = mem_din_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    we_d       = cpu_we;
                    size_d     = cpu_size;
                    eff_lo_d   = w_eff_in[1:0];
                    wdata_lo_d = cpu_wdata[15:0];
                    mem_addr_d = MEM_AW'(w_eff_in[16:2]);
                    if (!cpu_we) begin
                        state_d = ST_RD;
                    end else if (cpu_size[1]) begin
                        state_d   = ST_WR;
                        mem_we_d  = 1'b1;
                        mem_din_d = cpu_wdata;
                    end else if ((cpu_size == 2'd0) && (w_eff_in >= OBJ_BYTE_BASE)) begin
                        state_d   = ST_ACK;
                        cpu_ack_d = 1'b1;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                // The old word is merged as it is captured, so mem_din is ready in WR.
                if (we_q) begin
                    state_d   = ST_WR;
                    mem_we_d  = 1'b1;
                    mem_din_d = w_merged;
                end else begin
                    state_d     = ST_ACK;
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = w_rd_data;
                end
            end
            ST_WR: begin
                state_d   = ST_ACK;
                cpu_ack_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            eff_lo_q    <= 2'd0;
            wdata_lo_q  <= 16'h0;
            cpu_rdata_q <= 32'h0;
            cpu_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_din_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            eff_lo_q    <= eff_lo_d;
            wdata_lo_q  <= wdata_lo_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_din_q   <= mem_din_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_din   = mem_din_q;

endmodule
`default_nettype wire
